// File: rtl/issue_slot_gen.sv
// issue_slot_gen: a single issue-queue slot. Holds one uop, tracks operand
// readiness through tag wakeups (including speculative load-hit wakeups that
// can be revoked), requests issue, and splits two-part uops (addr + data)
// into separate issues when only one operand is ready.
module issue_slot_gen #(
    parameter int NUM_WAKEUP = 4,
    parameter int PREG_W     = 7,
    parameter int BR_MASK_W  = 12,
    parameter int INST_W     = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [1:0]                   in_state,
    input  logic [INST_W-1:0]            in_inst,
    input  logic [PREG_W-1:0]            in_prs1,
    input  logic [PREG_W-1:0]            in_prs2,
    input  logic                         in_prs1_busy,
    input  logic                         in_prs2_busy,
    input  logic [BR_MASK_W-1:0]         in_br_mask,
    input  logic [NUM_WAKEUP-1:0]        wakeup_valid,
    input  logic [NUM_WAKEUP*PREG_W-1:0] wakeup_pdst,
    input  logic [NUM_WAKEUP-1:0]        wakeup_spec,
    input  logic                         ld_miss,
    input  logic                         br_valid,
    input  logic                         br_mispredict,
    input  logic [BR_MASK_W-1:0]         br_onehot,
    input  logic                         grant,
    input  logic                         kill,
    input  logic                         clear,
    output logic                         valid,
    output logic                         will_be_valid,
    output logic                         request,
    output logic [1:0]                   out_state,
    output logic [INST_W-1:0]            out_inst,
    output logic [BR_MASK_W-1:0]         out_br_mask,
    output logic                         out_p1,
    output logic                         out_p2,
    output logic [1:0]                   issued_part
);

    localparam logic [1:0] ST_INVALID = 2'b00;
    localparam logic [1:0] ST_VALID_1 = 2'b01;
    localparam logic [1:0] ST_VALID_2 = 2'b10;

    logic [1:0]           state_reg, state_next;
    logic                 p1_reg, p1_next, p2_reg, p2_next;
    logic                 p1_poison_reg, p1_poison_next;
    logic                 p2_poison_reg, p2_poison_next;
    logic [INST_W-1:0]    inst_reg, inst_next;
    logic [BR_MASK_W-1:0] br_mask_reg, br_mask_next;
    logic [PREG_W-1:0]    prs1_reg, prs1_next, prs2_reg, prs2_next;

    // Per-port tag matches against the held tags and the incoming uop's tags.
    logic [NUM_WAKEUP-1:0] hit1_vec, hit2_vec, hit1_in_vec, hit2_in_vec;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WAKEUP; gi++) begin : g_wake
            logic [PREG_W-1:0] pdst;
            assign pdst            = wakeup_pdst[gi*PREG_W +: PREG_W];
            assign hit1_vec[gi]    = wakeup_valid[gi] && (pdst == prs1_reg);
            assign hit2_vec[gi]    = wakeup_valid[gi] && (pdst == prs2_reg);
            assign hit1_in_vec[gi] = wakeup_valid[gi] && (pdst == in_prs1);
            assign hit2_in_vec[gi] = wakeup_valid[gi] && (pdst == in_prs2);
        end
    endgenerate

    // Several matching ports act as one; any speculative one poisons the operand.
    logic hit1, hit2, hit1_in, hit2_in;
    logic spec1, spec2, spec1_in, spec2_in;
    assign hit1     = |hit1_vec;
    assign hit2     = |hit2_vec;
    assign hit1_in  = |hit1_in_vec;
    assign hit2_in  = |hit2_in_vec;
    assign spec1    = |(hit1_vec & wakeup_spec);
    assign spec2    = |(hit2_vec & wakeup_spec);
    assign spec1_in = |(hit1_in_vec & wakeup_spec);
    assign spec2_in = |(hit2_in_vec & wakeup_spec);

    logic                 br_kill, ready, grant_eff, full_issue;
    logic                 use1, use2, cancel;
    logic [1:0]           parts;
    logic [BR_MASK_W-1:0] br_resolved;

    // Issue request, issued part and grant cancellation for the current cycle.
    always_comb begin
        valid       = (state_reg != ST_INVALID);
        br_kill     = valid && br_valid && br_mispredict && |(br_mask_reg & br_onehot);
        br_resolved = (br_valid && !br_mispredict) ? br_onehot : '0;
        ready       = 1'b0;
        if (state_reg == ST_VALID_1) ready = p1_reg && p2_reg;
        if (state_reg == ST_VALID_2) ready = p1_reg || p2_reg;
        request     = valid && !kill && !br_kill && ready;
        grant_eff   = grant && request;
        full_issue  = (state_reg == ST_VALID_1) || (p1_reg && p2_reg);
        parts       = full_issue ? 2'b11 : (p1_reg ? 2'b01 : 2'b10);
        issued_part = grant_eff ? parts : 2'b00;
        // A granted operand that rode on a now-revoked load wakeup undoes the grant.
        use1        = full_issue || p1_reg;
        use2        = full_issue || (!p1_reg && p2_reg);
        cancel      = grant_eff && ld_miss &&
                      ((use1 && p1_poison_reg) || (use2 && p2_poison_reg));
        will_be_valid = valid && !kill && !br_kill && !(grant_eff && full_issue && !cancel);
    end

    // Next-state: operand tracking first, then the state priority chain.
    always_comb begin
        state_next     = state_reg;
        inst_next      = inst_reg;
        prs1_next      = prs1_reg;
        prs2_next      = prs2_reg;
        br_mask_next   = br_mask_reg & ~br_resolved;
        p1_next        = p1_reg;
        p2_next        = p2_reg;
        p1_poison_next = p1_poison_reg;
        p2_poison_next = p2_poison_reg;

        // Revocation applies to last cycle's wakeups; a fresh wakeup this cycle wins.
        if (ld_miss && p1_poison_reg) begin
            p1_next        = 1'b0;
            p1_poison_next = 1'b0;
        end
        if (ld_miss && p2_poison_reg) begin
            p2_next        = 1'b0;
            p2_poison_next = 1'b0;
        end
        if (hit1) begin
            p1_next        = 1'b1;
            p1_poison_next = spec1;
        end
        if (hit2) begin
            p2_next        = 1'b1;
            p2_poison_next = spec2;
        end

        if (kill) begin
            state_next = ST_INVALID;
        end else if (in_valid) begin
            state_next     = in_state;
            inst_next      = in_inst;
            prs1_next      = in_prs1;
            prs2_next      = in_prs2;
            br_mask_next   = in_br_mask & ~br_resolved;
            p1_next        = !in_prs1_busy || hit1_in;
            p2_next        = !in_prs2_busy || hit2_in;
            p1_poison_next = hit1_in && spec1_in;
            p2_poison_next = hit2_in && spec2_in;
        end else if (br_kill) begin
            state_next = ST_INVALID;
        end else if (grant_eff) begin
            if (!cancel) begin
                if (full_issue) begin
                    state_next = ST_INVALID;
                end else begin
                    // The issued half no longer gates the remaining half.
                    state_next = ST_VALID_1;
                    if (p1_reg) begin
                        p1_next        = 1'b1;
                        p1_poison_next = 1'b0;
                    end else begin
                        p2_next        = 1'b1;
                        p2_poison_next = 1'b0;
                    end
                end
            end
        end else if (clear) begin
            state_next = ST_INVALID;
        end
    end

    // Slot registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_INVALID;
            p1_reg        <= 1'b0;
            p2_reg        <= 1'b0;
            p1_poison_reg <= 1'b0;
            p2_poison_reg <= 1'b0;
            inst_reg      <= '0;
            br_mask_reg   <= '0;
            prs1_reg      <= '0;
            prs2_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            p1_reg        <= p1_next;
            p2_reg        <= p2_next;
            p1_poison_reg <= p1_poison_next;
            p2_poison_reg <= p2_poison_next;
            inst_reg      <= inst_next;
            br_mask_reg   <= br_mask_next;
            prs1_reg      <= prs1_next;
            prs2_reg      <= prs2_next;
        end
    end

    assign out_state   = state_reg;
    assign out_inst    = inst_reg;
    assign out_br_mask = br_mask_reg;
    assign out_p1      = p1_reg;
    assign out_p2      = p2_reg;

endmodule
